// File: rtl/bcd_event_counter.sv
// bcd_event_counter
// Counts the selected edge of an asynchronous detector pin in DIGITS BCD
// digits. It has two modes:
//   - totalise: counts up or down, and either wraps or saturates at the ends.
//   - gated: counts events per GATE_CYCLES window and latches each result.
// det_counter is the live count. det_latched holds either a snapshot or the
// count of the last completed window.
module bcd_event_counter #(
  parameter int DIGITS      = 4,
  parameter int EDGE        = 0,
  parameter int SAT         = 0,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_CYCLES = 1000000
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  detector,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  mode,
  input  logic                  dir,
  input  logic                  snap,
  output logic [4*DIGITS-1:0]   det_counter,
  output logic [4*DIGITS-1:0]   det_latched,
  output logic                  valid,
  output logic                  ovf
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  // The sync chain and the history flop rest at the level the pin idles at
  // between counted edges. Releasing reset therefore never looks like an edge.
  localparam logic          IDLE      = (EDGE == 0) ? 1'b1 : 1'b0;
  localparam logic          SAT_EN    = (SAT != 0);
  localparam logic [TW-1:0] LAST_TICK = TW'(GATE_CYCLES - 1);

  // One BCD step across all digits in a single cycle.
  // Bit W is the carry/borrow out of the top digit. It is set only when the
  // value wraps: all-nines -> zero going up, or zero -> all-nines going down.
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
            c           = 1'b1;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c           = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
            c           = 1'b1;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c           = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_mode_prev;
  logic [W-1:0]           r_count;
  logic [W-1:0]           r_latched;
  logic [TW-1:0]          r_timer;
  logic                   r_valid;
  logic                   r_ovf;

  logic                   w_sync_out;
  logic                   w_ev;
  logic                   w_up;
  logic [W:0]             w_step;
  logic [W-1:0]           w_next_count;
  logic                   w_next_ovf;
  logic                   w_clear;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_ev       = (EDGE != 0) ? (w_sync_out & ~r_hist) : (~w_sync_out & r_hist);

  // Gated mode always counts up. dir only matters in totalise mode.
  assign w_up    = mode ? 1'b1 : dir;
  assign w_step  = bcd_step(r_count, w_up);

  // A mode switch restarts counting exactly as an explicit clear does.
  assign w_clear = clr | (mode != r_mode_prev);

  // Synchronise the detector pin and keep one cycle of history for the edge compare.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_sync <= {SYNC_STAGES{IDLE}};
      r_hist <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop in
      // the chain samples its pre-edge input and the chain shifts by exactly one stage.
      r_sync <= {r_sync[SYNC_STAGES-2:0], detector};
      r_hist <= w_sync_out;
    end
  end

  // Count value and overflow flag after this cycle's event, before clear and window-end handling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    w_next_count = r_count;
    w_next_ovf   = r_ovf;
    if (en && w_ev) begin
      if (w_step[W]) begin
        // At a range end: saturate holds the current value (all-nines going up,
        // zero going down); wrap takes the stepped value.
        w_next_ovf = 1'b1;
        if (!(mode || SAT_EN)) begin
          w_next_count = w_step[W-1:0];
        end
      end else begin
        w_next_count = w_step[W-1:0];
      end
    end
  end

  // Count, gate timer, latch and valid pulse.
  // Priority order: clear/mode change first, then window end or snap, then the event.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_mode_prev <= 1'b0;
      r_count     <= '0;
      r_latched   <= '0;
      r_timer     <= '0;
      r_valid     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_mode_prev <= mode;
      r_valid     <= 1'b0;
      if (w_clear) begin
        r_count <= '0;
        r_timer <= '0;
        r_ovf   <= 1'b0;
      end else if (!mode) begin
        r_count <= w_next_count;
        r_ovf   <= w_next_ovf;
        if (snap) begin
          r_latched <= w_next_count;
          r_valid   <= 1'b1;
        end
      end else if (en) begin
        r_ovf <= w_next_ovf;
        if (r_timer == LAST_TICK) begin
          // The window closes with this cycle's event included; the next window starts from zero.
          r_latched <= w_next_count;
          r_count   <= '0;
          r_timer   <= '0;
          r_valid   <= 1'b1;
        end else begin
          r_count <= w_next_count;
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign det_counter = r_count;
  assign det_latched = r_latched;
  assign valid       = r_valid;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_bcd_event_counter.sv
// tb_bcd_event_counter
// Runs two DUT instances on shared stimulus. Both have 4 digits, count
// falling edges, use 2 sync stages and a 100-cycle gate window; one wraps
// (SAT=0) and one saturates (SAT=1). A totalise vector table covers the main
// counting behaviour. Hand-written sequences cover reset, latency, snap,
// collisions and gated mode.
module tb_bcd_event_counter;

  logic        CP = 1'b0;
  logic        CR;
  logic        detector;
  logic        en;
  logic        clr;
  logic        mode;
  logic        dir;
  logic        snap;
  logic [15:0] cnt_w, lat_w, cnt_s, lat_s;
  logic        val_w, ovf_w, val_s, ovf_s;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CP = ~CP;

  bcd_event_counter #(
    .DIGITS(4), .EDGE(0), .SAT(0), .SYNC_STAGES(2), .GATE_CYCLES(100)
  ) u_wrap (
    .CP(CP), .CR(CR), .detector(detector), .en(en), .clr(clr), .mode(mode),
    .dir(dir), .snap(snap), .det_counter(cnt_w), .det_latched(lat_w),
    .valid(val_w), .ovf(ovf_w)
  );

  bcd_event_counter #(
    .DIGITS(4), .EDGE(0), .SAT(1), .SYNC_STAGES(2), .GATE_CYCLES(100)
  ) u_sat (
    .CP(CP), .CR(CR), .detector(detector), .en(en), .clr(clr), .mode(mode),
    .dir(dir), .snap(snap), .det_counter(cnt_s), .det_latched(lat_s),
    .valid(val_s), .ovf(ovf_s)
  );

  typedef struct {
    logic        clr;
    logic        en;
    logic        dir;
    int          n;
    logic [15:0] cw;
    logic [15:0] cs;
    logic        ow;
    logic        os;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // n one-cycle low pulses on the detector; each one is a falling edge.
  task automatic pulse_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CP); #1 detector = 1'b0;
      @(posedge CP); #1 detector = 1'b1;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge CP);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge CP); #1 clr = 1'b1;
    @(posedge CP); #1 clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pulse;
    int found_k;

    // {clr, en, dir, edges, expected count wrap, expected count sat, ovf wrap, ovf sat}
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 0,    16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1234, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 0,    16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 999,  16'h0999, 16'h0999, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1,    16'h1000, 16'h1000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1,    16'h0999, 16'h0999, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 0,    16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1,    16'h9999, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 5,    16'h9999, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 0,    16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 9999, 16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1,    16'h0000, 16'h9999, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3,    16'h9997, 16'h9996, 1'b1, 1'b1};

    // Reset asserted before the first clock edge: outputs must clear asynchronously.
    CR = 1'b1; detector = 1'b1; en = 1'b1; clr = 1'b0; mode = 1'b0; dir = 1'b1; snap = 1'b0;
    #1;
    check("rst_cnt_w", cnt_w, 16'h0000);
    check("rst_lat_w", lat_w, 16'h0000);
    check("rst_val_w", val_w, 1'b0);
    check("rst_ovf_w", ovf_w, 1'b0);
    check("rst_cnt_s", cnt_s, 16'h0000);
    repeat (2) @(negedge CP);
    CR = 1'b0;
    repeat (5) @(posedge CP);
    #1;
    check("rel_cnt_w", cnt_w, 16'h0000);
    check("rel_val_w", val_w, 1'b0);

    // Totalise vector table.
    for (int i = 0; i < 13; i++) begin
      en  = vecs[i].en;
      dir = vecs[i].dir;
      if (vecs[i].clr) pulse_clr();
      pulse_edges(vecs[i].n);
      drain();
      en = 1'b1;
      check($sformatf("vec%0d_cnt_wrap", i), cnt_w, vecs[i].cw);
      check($sformatf("vec%0d_cnt_sat", i),  cnt_s, vecs[i].cs);
      check($sformatf("vec%0d_ovf_wrap", i), ovf_w, vecs[i].ow);
      check($sformatf("vec%0d_ovf_sat", i),  ovf_s, vecs[i].os);
    end

    // Reset while counting, with an edge still in the synchroniser.
    @(posedge CP); #1 detector = 1'b0;
    @(posedge CP); #3 CR = 1'b1;
    #1;
    check("midrst_cnt_w", cnt_w, 16'h0000);
    check("midrst_cnt_s", cnt_s, 16'h0000);
    check("midrst_ovf_w", ovf_w, 1'b0);
    check("midrst_ovf_s", ovf_s, 1'b0);
    detector = 1'b1;
    repeat (2) @(negedge CP);
    CR = 1'b0;
    repeat (6) @(posedge CP);
    #1;
    check("midrel_cnt_w", cnt_w, 16'h0000);
    check("midrel_val_w", val_w, 1'b0);
    check("midrel_lat_w", lat_w, 16'h0000);

    // Latency: the count changes on the third rising edge after the detector falls.
    dir = 1'b1;
    detector = 1'b0;
    @(posedge CP); #1;
    @(posedge CP); #1;
    check("lat_edge2_cnt", cnt_w, 16'h0000);
    @(posedge CP); #1;
    check("lat_edge3_cnt", cnt_w, 16'h0001);
    detector = 1'b1;
    drain();
    check("lat_rise_ignored", cnt_w, 16'h0001);

    // Snap with no event pending.
    @(posedge CP); #1 snap = 1'b1;
    @(posedge CP); #1 snap = 1'b0;
    check("snap_valid", val_w, 1'b1);
    check("snap_lat_w", lat_w, 16'h0001);
    check("snap_lat_s", lat_s, 16'h0001);
    @(posedge CP); #1;
    check("snap_valid_one_cycle", val_w, 1'b0);

    // Snap in the same cycle as an event: the latch takes the updated count.
    detector = 1'b0;
    @(posedge CP); #1 detector = 1'b1;
    @(posedge CP); #1 snap = 1'b1;
    @(posedge CP); #1 snap = 1'b0;
    check("snapev_cnt", cnt_w, 16'h0002);
    check("snapev_lat", lat_w, 16'h0002);
    check("snapev_valid", val_w, 1'b1);
    drain();

    // Set ovf by counting down from zero, then clear in the same cycle as an event.
    pulse_clr();
    dir = 1'b0;
    pulse_edges(1);
    drain();
    check("under_cnt_w", cnt_w, 16'h9999);
    check("under_cnt_s", cnt_s, 16'h0000);
    check("under_ovf_s", ovf_s, 1'b1);
    detector = 1'b0;
    @(posedge CP); #1 detector = 1'b1;
    @(posedge CP); #1 clr = 1'b1;
    @(posedge CP); #1 clr = 1'b0;
    check("clrev_cnt_w", cnt_w, 16'h0000);
    check("clrev_ovf_w", ovf_w, 1'b0);
    check("clrev_ovf_s", ovf_s, 1'b0);
    drain();
    check("clrev_dropped_w", cnt_w, 16'h0000);
    check("clrev_dropped_ovf", ovf_w, 1'b0);

    // Gated mode: detector period 8 cycles, 100-cycle windows.
    // The mode change is taken at loop edge i=1, so windows close at i=101, 201 and 301.
    dir = 1'b1;
    mode = 1'b1;
    n_pulse = 0;
    for (int i = 1; i <= 350; i++) begin
      @(posedge CP); #1;
      if (i % 4 == 0) detector = ~detector;
      if (val_w) begin
        n_pulse++;
        check("gate_pulse_pos", i, 101 + 100 * (n_pulse - 1));
        check("gate_lat_w_range", ((lat_w == 16'h0012) || (lat_w == 16'h0013)), 1'b1);
        check("gate_lat_s_range", ((lat_s == 16'h0012) || (lat_s == 16'h0013)), 1'b1);
      end
    end
    check("gate_pulse_count", n_pulse, 3);
    check("gate_ovf", ovf_w, 1'b0);

    // en=0 freezes the gate timer and ignores edges.
    detector = 1'b1;
    drain();
    pulse_clr();
    repeat (50) @(posedge CP);
    #1 en = 1'b0;
    pulse_edges(5);
    drain();
    drain();
    check("freeze_cnt_w", cnt_w, 16'h0000);
    check("freeze_cnt_s", cnt_s, 16'h0000);
    en = 1'b1;
    pulse_edges(3);
    drain();
    check("thaw_cnt_w", cnt_w, 16'h0003);
    found_k = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge CP); #1;
      if (val_w && found_k == 0) found_k = k;
      if (found_k != 0) break;
    end
    check("freeze_window_end", found_k, 40);
    check("freeze_lat_w", lat_w, 16'h0003);
    check("freeze_cnt_restart", cnt_w, 16'h0000);

    // An event in the window-end cycle belongs to the closing window.
    repeat (97) @(posedge CP);
    #1 detector = 1'b0;
    @(posedge CP); #1 detector = 1'b1;
    @(posedge CP); #1;
    check("wend_valid_early", val_w, 1'b0);
    @(posedge CP); #1;
    check("wend_valid", val_w, 1'b1);
    check("wend_lat_w", lat_w, 16'h0001);
    check("wend_cnt_w", cnt_w, 16'h0000);
    drain();
    check("wend_new_window", cnt_w, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
